uart_rx_tx: RTL and testbench

Full-duplex 8N1 UART: one transmitter and one receiver sharing a single clock and a compile-time baud divider. The host loads a byte with a start strobe and ready handshake. The receiver presents each correctly framed byte with a one-cycle valid pulse. It sits between the chip's serial pins and byte-level control logic, and must support external TX→RX loopback.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fsm.sv | 95 +++++++++
 rtl/uart_rx_tx.sv | 105 ++++++++++
 tb/tb_uart_rx_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART: FSM state encodings and the
// baud divider calculation used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// 8N1 receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// single-cycle valid strobe for each correctly framed byte.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk_10ns,
  input  logic              uart_reset,
  input  logic              uart_rx_d_in,
  output logic [DATA_W-1:0] uart_received_data,
  output logic              uart_rx_valid
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t         rx_state;
  logic [1:0]        rx_sync;
  logic              rx_s;
  logic [CNT_W-1:0]  rx_cnt;
  logic [2:0]        rx_bit;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_frame_err;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk_10ns or posedge uart_reset) begin
    if (uart_reset) begin
      rx_sync            <= 2'b11;
      rx_state           <= RX_IDLE;
      rx_cnt             <= '0;
      rx_bit             <= '0;
      rx_shift           <= '0;
      rx_frame_err       <= 1'b0;
      uart_received_data <= '0;
      uart_rx_valid      <= 1'b0;
    end else begin
      rx_sync       <= {rx_sync[0], uart_rx_d_in};
      uart_rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[DATA_W-1:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) begin
              rx_frame_err <= 1'b0;
              rx_state     <= RX_STOP;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // A bad stop bit parks here until the line recovers, so a held-low
          // line is not mistaken for the next start bit.
          if (rx_frame_err) begin
            if (rx_s) begin
              rx_frame_err <= 1'b0;
              rx_state     <= RX_IDLE;
            end
          end else if (rx_cnt == CNT_LAST) begin
            rx_cnt <= '0;
            if (rx_s) begin
              uart_received_data <= rx_shift;
              uart_rx_valid      <= 1'b1;
              rx_state           <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_tx.sv
// Full-duplex 8N1 UART top: transmitter FSM with start/ready handshake plus
// the receiver sub-module; both share one clock and one baud divider.
module uart_rx_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_FREQ = 100000000
) (
  input  logic              clk_10ns,
  input  logic              uart_reset,
  input  logic [DATA_W-1:0] uart_transmit_data,
  input  logic              uart_rx_d_in,
  input  logic              uart_tx_start,
  output logic              uart_tx_d_out,
  output logic [DATA_W-1:0] uart_received_data,
  output logic              uart_rx_valid,
  output logic              uart_tx_ready
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_divider
    $error("uart_rx_tx: CLOCK_FREQ/BAUD_RATE must be at least 4");
  end

  tx_state_t         tx_state;
  logic [CNT_W-1:0]  tx_cnt;
  logic [2:0]        tx_bit;
  logic [DATA_W-1:0] tx_shift;

  assign uart_tx_ready = (tx_state == TX_IDLE);

  // The line is registered so it changes on the same edge as the state.
  always_ff @(posedge clk_10ns or posedge uart_reset) begin
    if (uart_reset) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_shift      <= '0;
      uart_tx_d_out <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          if (uart_tx_start) begin
            tx_shift      <= uart_transmit_data;
            uart_tx_d_out <= 1'b0;
            tx_state      <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt        <= '0;
            uart_tx_d_out <= tx_shift[0];
            tx_shift      <= tx_shift >> 1;
            tx_state      <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) begin
              uart_tx_d_out <= 1'b1;
              tx_state      <= TX_STOP;
            end else begin
              uart_tx_d_out <= tx_shift[0];
              tx_shift      <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          uart_tx_d_out <= 1'b1;
          tx_state      <= TX_IDLE;
        end
      endcase
    end
  end

  uart_rx_fsm #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_10ns          (clk_10ns),
    .uart_reset        (uart_reset),
    .uart_rx_d_in      (uart_rx_d_in),
    .uart_received_data(uart_received_data),
    .uart_rx_valid     (uart_rx_valid)
  );

endmodule

// File: tb/tb_uart_rx_tx.sv
// Bench for uart_rx_tx: TX looped to RX, scoreboard of expected received
// bytes popped by a monitor on every valid pulse, plus direct line checks.
module tb_uart_rx_tx;

  localparam int BAUD = 1500000;
  localparam int CF   = 10000000;
  localparam int CPB  = CF / BAUD;
  localparam int FRAME = 10 * CPB;

  logic       clk_10ns = 1'b0;
  logic       uart_reset;
  logic [7:0] uart_transmit_data;
  logic       uart_rx_d_in;
  logic       uart_tx_start;
  logic       uart_tx_d_out;
  logic [7:0] uart_received_data;
  logic       uart_rx_valid;
  logic       uart_tx_ready;

  logic loop_en;
  logic tb_line;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rx;

  assign uart_rx_d_in = loop_en ? uart_tx_d_out : tb_line;

  always #5 clk_10ns = ~clk_10ns;

  uart_rx_tx #(
    .BAUD_RATE (BAUD),
    .CLOCK_FREQ(CF)
  ) dut (
    .clk_10ns          (clk_10ns),
    .uart_reset        (uart_reset),
    .uart_transmit_data(uart_transmit_data),
    .uart_rx_d_in      (uart_rx_d_in),
    .uart_tx_start     (uart_tx_start),
    .uart_tx_d_out     (uart_tx_d_out),
    .uart_received_data(uart_received_data),
    .uart_rx_valid     (uart_rx_valid),
    .uart_tx_ready     (uart_tx_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model of a frame on the wire: index 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Scoreboard monitor: every valid pulse must match the oldest expected byte.
  always @(negedge clk_10ns) begin
    if (uart_rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rx_valid_unexpected", 32'(uart_rx_valid), 32'h0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rx_data", 32'(uart_received_data), 32'(e));
        last_rx = e;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    while (uart_tx_ready !== 1'b1 && k < 200) begin
      @(negedge clk_10ns);
      k++;
    end
    if (k >= 200) check("tx_ready_timeout", 32'(uart_tx_ready), 32'h1);
    uart_tx_start      = 1'b1;
    uart_transmit_data = b;
    exp_q.push_back(b);
    @(negedge clk_10ns);
    uart_tx_start      = 1'b0;
    uart_transmit_data = 8'($urandom);
    check("accept_ready_low", 32'(uart_tx_ready), 32'h0);
    check("accept_start_bit", 32'(uart_tx_d_out), 32'h0);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(uart_tx_ready === 1'b1 && exp_q.size() == 0) && k < budget) begin
      @(negedge clk_10ns);
      k++;
    end
    if (k >= budget) check("drain_timeout_pending", exp_q.size(), 32'h0);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      tb_line = (k == 9) ? stop : frame_bit(b, k);
      repeat (CPB) @(negedge clk_10ns);
    end
  endtask

  initial begin
    logic [7:0] prev;
    int k;
    uart_reset         = 1'b1;
    uart_tx_start      = 1'b0;
    uart_transmit_data = 8'h00;
    loop_en            = 1'b1;
    tb_line            = 1'b1;
    last_rx            = 8'h00;

    // 1. reset values, held and after release
    repeat (3) @(negedge clk_10ns);
    check("rst_tx_d_out", 32'(uart_tx_d_out), 32'h1);
    check("rst_tx_ready", 32'(uart_tx_ready), 32'h1);
    check("rst_rx_valid", 32'(uart_rx_valid), 32'h0);
    check("rst_rx_data", 32'(uart_received_data), 32'h0);
    uart_reset = 1'b0;
    repeat (10) @(negedge clk_10ns);
    check("idle_tx_d_out", 32'(uart_tx_d_out), 32'h1);
    check("idle_tx_ready", 32'(uart_tx_ready), 32'h1);
    check("idle_rx_data", 32'(uart_received_data), 32'h0);

    // 2. single byte, bit-exact line check
    send_byte(8'h02);
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("line_0x02_c%0d", i), 32'(uart_tx_d_out), 32'(frame_bit(8'h02, i / CPB)));
      check($sformatf("busy_0x02_c%0d", i), 32'(uart_tx_ready), 32'h0);
      @(negedge clk_10ns);
    end
    check("ready_after_frame", 32'(uart_tx_ready), 32'h1);
    check("line_after_frame", 32'(uart_tx_d_out), 32'h1);
    wait_idle(200);

    // 3. alternating pattern then random bytes with random gaps
    for (int n = 0; n < 20; n++) begin
      send_byte((n % 2) ? 8'h0A : 8'h02);
      repeat ($urandom_range(0, 40)) @(negedge clk_10ns);
    end
    for (int n = 0; n < 16; n++) begin
      send_byte(8'($urandom));
      repeat ($urandom_range(0, 20)) @(negedge clk_10ns);
    end
    wait_idle(400);
    check("rx_data_after_random", 32'(uart_received_data), 32'(last_rx));

    // 4. start held high: back-to-back frames with one ready cycle between
    uart_tx_start      = 1'b1;
    uart_transmit_data = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk_10ns);
    check("b2b_first_busy", 32'(uart_tx_ready), 32'h0);
    uart_transmit_data = 8'hA5;
    exp_q.push_back(8'hA5);
    k = 0;
    while (uart_tx_ready !== 1'b1 && k < 100) begin
      @(negedge clk_10ns);
      k++;
    end
    check("b2b_busy_cycles", k, FRAME);
    @(negedge clk_10ns);
    check("b2b_second_busy", 32'(uart_tx_ready), 32'h0);
    check("b2b_second_start", 32'(uart_tx_d_out), 32'h0);
    uart_tx_start = 1'b0;
    wait_idle(200);

    // 5. framing error and glitch, driven directly on the RX pin
    loop_en = 1'b0;
    tb_line = 1'b1;
    repeat (10) @(negedge clk_10ns);
    prev = uart_received_data;
    drive_frame(8'h3C, 1'b0);
    tb_line = 1'b0;
    repeat (12) @(negedge clk_10ns);
    tb_line = 1'b1;
    repeat (20) @(negedge clk_10ns);
    check("frame_err_keeps_data", 32'(uart_received_data), 32'(prev));
    tb_line = 1'b0;
    repeat (2) @(negedge clk_10ns);
    tb_line = 1'b1;
    repeat (80) @(negedge clk_10ns);
    check("glitch_keeps_data", 32'(uart_received_data), 32'(prev));
    exp_q.push_back(8'hC3);
    drive_frame(8'hC3, 1'b1);
    repeat (10) @(negedge clk_10ns);
    wait_idle(100);
    loop_en = 1'b1;

    // 6. reset in the middle of a frame
    send_byte(8'hFF);
    repeat (25) @(negedge clk_10ns);
    uart_reset = 1'b1;
    #1;
    check("midrst_tx_d_out", 32'(uart_tx_d_out), 32'h1);
    check("midrst_tx_ready", 32'(uart_tx_ready), 32'h1);
    check("midrst_rx_valid", 32'(uart_rx_valid), 32'h0);
    check("midrst_rx_data", 32'(uart_received_data), 32'h0);
    exp_q.delete();
    last_rx = 8'h00;
    repeat (2) @(negedge clk_10ns);
    uart_reset = 1'b0;
    repeat (5) @(negedge clk_10ns);
    send_byte(8'h81);
    wait_idle(200);
    repeat (20) @(negedge clk_10ns);
    check("post_reset_rx_data", 32'(uart_received_data), 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
